// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadows a nibble word, scans one digit per DIV cycles.
// Define SEG7_HEX_EN to render nibbles 10..15 as hex glyphs; otherwise those digits are dark.
module seg7_scan_driver #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  enable,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LastDigit = CW'(DIGITS - 1);
    localparam logic [PW-1:0] LastTick  = PW'(DIV - 1);

    logic [PW-1:0]         pre_q, pre_d;
    logic [CW-1:0]         cur_q, cur_d;
    logic [4*DIGITS-1:0]   value_q, value_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic                  pend_q, pend_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_out_q, dp_out_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  fd_q, fd_d;

    logic [DIGITS-1:0]     lz_zero;
    logic                  above_zero;
    logic [3:0]            nib;
    logic                  blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1110011;
`ifdef SEG7_HEX_EN
            4'd10:   s = 7'b1110111;
            4'd11:   s = 7'b0011111;
            4'd12:   s = 7'b1001110;
            4'd13:   s = 7'b0111101;
            4'd14:   s = 7'b1001111;
            4'd15:   s = 7'b1000111;
`endif
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan counters; pend marks that the next enabled cycle starts a new frame.
    always_comb begin
        pre_d  = pre_q;
        cur_d  = cur_q;
        pend_d = pend_q;
        if (enable) begin
            pend_d = 1'b0;
            if (pre_q == LastTick) begin
                pre_d = '0;
                if (cur_q == LastDigit) begin
                    cur_d  = '0;
                    pend_d = 1'b1;
                end else begin
                    cur_d = cur_q + CW'(1);
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_comb begin
        value_d = load ? value : value_q;
        dp_d    = load ? dp : dp_q;
    end

    // lz_zero[k]: nibble k and every nibble above it are zero.
    always_comb begin
        lz_zero    = '0;
        above_zero = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            above_zero = above_zero && (value_q[4*k +: 4] == 4'd0);
            lz_zero[k] = above_zero;
        end
    end

    always_comb begin
        nib      = value_q[{cur_q, 2'b00} +: 4];
        blank    = lz_blank && (cur_q != '0) && lz_zero[cur_q];
        seg_d    = '0;
        an_d     = '0;
        dp_out_d = 1'b0;
        fd_d     = 1'b0;
        if (enable) begin
            seg_d    = blank ? 7'b0000000 : decode(nib);
            an_d     = DIGITS'(1) << cur_q;
            dp_out_d = dp_q[cur_q];
            fd_d     = pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= '0;
            cur_q    <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            pend_q   <= 1'b1;
            seg_q    <= '0;
            dp_out_q <= 1'b0;
            an_q     <= '0;
            fd_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cur_q    <= cur_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            pend_q   <= pend_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, DIV=4; define SEG7_HEX_EN for the hex build.
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;

`ifdef SEG7_HEX_EN
    localparam logic [6:0] GlyphA = 7'b1110111;
    localparam logic [6:0] GlyphF = 7'b1000111;
`else
    localparam logic [6:0] GlyphA = 7'b0000000;
    localparam logic [6:0] GlyphF = 7'b0000000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        load;
    logic        enable;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS(DIGITS),
        .DIV   (DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .dp        (dp),
        .load      (load),
        .enable    (enable),
        .lz_blank  (lz_blank),
        .seg       (seg),
        .dp_out    (dp_out),
        .an        (an),
        .frame_done(frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_fd);
        chk({tag, ".an"}, {3'b000, an}, {3'b000, e_an});
        chk({tag, ".seg"}, seg, e_seg);
        chk({tag, ".dp_out"}, {6'b0, dp_out}, {6'b0, e_dp});
        chk({tag, ".frame_done"}, {6'b0, frame_done}, {6'b0, e_fd});
    endtask

    // Checks one full frame, starting from the cycle digit 0 first appears.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] dpm);
        logic [6:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 16; i++) begin
            int d;
            step();
            d = i / 4;
            chk_out($sformatf("%s.c%0d", tag, i), 4'(1 << d), s[d], dpm[d], i == 0);
        end
    endtask

    // Load lands on the first edge of a frame, so the following frame shows it throughout.
    task automatic load_and_skip(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk("load.frame_done", {6'b0, frame_done}, 7'd1);
        repeat (15) step();
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        enable   = 1'b1;
        lz_blank = 1'b0;
        value    = '0;
        dp       = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("reset%0d", i), 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end
        rst = 1'b0;
        check_frame("post_reset", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000);

        load_and_skip(16'h1234, 4'b0100);
        check_frame("v1234", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 4'b0100);
        check_frame("v1234_again", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 4'b0100);

        lz_blank = 1'b1;
        load_and_skip(16'h0070, 4'b0000);
        check_frame("lz0070", 7'b1111110, 7'b1110000, 7'b0000000, 7'b0000000, 4'b0000);

        load_and_skip(16'h0000, 4'b0000);
        check_frame("lz0000", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000);

        // Blanked digits 2 and 3 keep their decimal points.
        load_and_skip(16'h00AF, 4'b1111);
        check_frame("hex00AF", GlyphF, GlyphA, 7'b0000000, 7'b0000000, 4'b1111);

        lz_blank = 1'b0;
        load_and_skip(16'h1234, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("en.d0c%0d", i), 4'b0001, 7'b0110011, 1'b0, i == 0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("en.d1c%0d", i), 4'b0010, 7'b1111001, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out($sformatf("en.d2c%0d", i), 4'b0100, 7'b1101101, 1'b0, 1'b0);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                value = 16'h5678;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            step();
            chk_out($sformatf("dark%0d", i), 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_out($sformatf("resume.d2c%0d", i), 4'b0100, 7'b1011111, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out($sformatf("resume.d3c%0d", i), 4'b1000, 7'b1011011, 1'b0, 1'b0);
        end
        step();
        chk_out("resume.wrap", 4'b0001, 7'b1111111, 1'b0, 1'b1);
        step();
        step();

        rst   = 1'b1;
        value = 16'hFFFF;
        dp    = 4'b1111;
        load  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            load = 1'b0;
            chk_out($sformatf("midreset%0d", i), 4'b0000, 7'b0000000, 1'b0, 1'b0);
        end
        rst = 1'b0;
        check_frame("after_midreset", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a row of DIGITS common-anode/cathode 7-segment digits. It captures a packed nibble word on a load strobe and scans one digit at a time at a programmable refresh rate. Per digit it drives segment patterns, a decimal point and leading-zero blanking. It sits between the datapath's BCD/hex result registers and the board's display pins, and supersedes single-digit, purely combinational decoding.

## Interface
Parameters:
- DIGITS, 4: number of digits scanned; legal 1..8.
- DIV, 1000: clock cycles each digit is held; legal ≥1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- value  in  4*DIGITS  packed nibbles; digit 0 (rightmost) at [3:0], digit k at [4k+3:4k].
- dp  in  DIGITS  decimal point request per digit, bit k ↔ digit k.
- load  in  1  captures value/dp into the shadow register at this edge.
- enable  in  1  1 = scan and drive; 0 = display dark, scan frozen.
- lz_blank  in  1  1 = suppress leading zeros.
- seg  out  7  {a,b,c,d,e,f,g}, active-high.
- dp_out  out  1  decimal point, active-high.
- an  out  DIGITS  one-hot digit select, active-high.
- frame_done  out  1  one-cycle pulse marking start of a new scan frame.

## Operation
- Shadow register (value, dp) loads on any edge with load=1. Otherwise it holds. The display only ever shows shadow contents.
- Prescaler counts 0..DIV-1 while enable=1.
- At the edge where the prescaler equals DIV-1:
  - the prescaler wraps to 0;
  - digit index cur advances; DIGITS-1 wraps to 0.
- Decode, nibble → seg:
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011.
  - 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1110011.
  - 10–15: see Configuration.
- Leading-zero blank: digit k>0 shows seg=0000000 when lz_blank=1, nibble k=0 and all nibbles above k are 0.
  - Digit 0 is never blanked.
  - an still selects a blanked digit.
  - dp_out still follows dp[k].
- enable=0:
  - prescaler and cur hold;
  - an, seg, dp_out and frame_done are driven 0;
  - load still works.
- DIGITS=1: cur is constantly 0, an=1, and frame_done pulses every DIV cycles.
- Priority: rst > load/enable. A load coincident with rst is discarded.

## Timing
- Reset values: prescaler 0, cur 0, shadow 0, an 0, seg 0000000, dp_out 0, frame_done 0.
- an, seg, dp_out and frame_done are registered from cur and the shadow. They reflect cur one cycle after cur changes.
- First cycle after rst drops with enable=1: an=…0001 and seg shows digit 0 of the shadow (0 → 1111110).
- Each digit is displayed for exactly DIV consecutive cycles. A full frame is DIGITS*DIV cycles.
- Load latency: shadow updates at the load edge. A change is visible on seg/dp_out at the next edge, provided the digit is currently selected.
- frame_done is high for exactly the one cycle in which an first shows digit 0 of a new frame. This includes the first cycle after reset.
- enable 1→0: outputs go dark at the next edge.
- enable 0→1: scanning resumes on the same digit with the remaining prescaler count. Outputs reappear at the next edge. frame_done does not re-pulse on resume.
- rst mid-frame: state returns to reset values at that edge, regardless of load/enable.

## Configuration
- SEG7_HEX_EN defined: nibbles 10–15 render hex glyphs A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
- Not defined: nibbles 10–15 render 0000000 (digit dark; an and dp_out unaffected).
- Leading-zero logic compares nibbles to 0 in both builds.

## Test plan
All scenarios use DIGITS=4, DIV=4.
- Reset: rst held 3 cycles → all outputs 0. Release → next cycle an=0001, seg=1111110, frame_done=1 for 1 cycle.
- Load value=16'h1234, dp=4'b0100:
  - an steps 0001/0010/0100/1000, 4 cycles each;
  - seg 0110011/1111001/1101101/0110000;
  - dp_out=1 only while an=0100;
  - frame_done pulses every 16 cycles.
- lz_blank=1, value=16'h0070 → digits 3,2 seg=0000000, digit 1 1110000, digit 0 1111110. With value=16'h0000 only digit 0 lit (1111110).
- value=16'h00AF: with SEG7_HEX_EN → digit 1 1110111, digit 0 1000111. Without it → both 0000000.
- enable=0 on the 2nd cycle of digit 2:
  - next cycle an=0, seg=0;
  - hold 10 cycles, then re-enable → an=0100 for exactly 2 more cycles, then 1000.
- rst asserted mid-frame together with load of 16'hFFFF → shadow stays 0. Outputs match the reset scenario.
